// File: rtl/fifo_wr_front.sv
// fifo_wr_front: write-side front end of the asynchronous FIFO.
// A 2-entry skid buffer feeds wr_inc/wr_data into the write-pointer block and memory.
// The Gray read pointer is synchronized into wr_clk and exposed as rd_ptr_sync.
// A registered fill level is derived from both Gray pointers.
// Optional feature macro: FIFO_WR_FRONT_ALMOST_FULL_EN adds a registered almost_full output.
module fifo_wr_front #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADD_WIDTH   = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AF_LEVEL    = 12
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADD_WIDTH:0]    rd_ptr_async,
  input  logic [ADD_WIDTH:0]    wr_ptr,
  input  logic                  wr_full,
  output logic [ADD_WIDTH:0]    rd_ptr_sync,
  output logic                  wr_inc,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADD_WIDTH:0]    fill_level
`ifdef FIFO_WR_FRONT_ALMOST_FULL_EN
  ,
  output logic                  almost_full
`endif
);

  // A single-flop crossing is not metastability-safe, and the threshold must be reachable.
  if (SYNC_STAGES < 2 || AF_LEVEL > (1 << ADD_WIDTH)) begin : g_bad_cfg
    $error("fifo_wr_front: SYNC_STAGES must be >= 2 and AF_LEVEL <= 2**ADD_WIDTH");
  end

  // Skid buffer occupancy
  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_FULL  = 2'd2
  } skid_state_t;

  skid_state_t           occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  rst_done_q;
  logic                  push;

  logic [ADD_WIDTH:0]    sync_q [SYNC_STAGES];
  logic [ADD_WIDTH:0]    wr_bin;
  logic [ADD_WIDTH:0]    rd_bin;
  logic [ADD_WIDTH:0]    fill_d;

  function automatic logic [ADD_WIDTH:0] gray2bin(input logic [ADD_WIDTH:0] g);
    logic [ADD_WIDTH:0] b;
    b            = '0;
    b[ADD_WIDTH] = g[ADD_WIDTH];
    for (int unsigned i = ADD_WIDTH; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

  // Holds in_ready low until the first wr_clk edge after reset release
  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      rst_done_q <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
    end
  end

  // Skid buffer state and storage registers
  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      occ_q  <= SK_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Handshake outputs and next occupancy; the head entry is always the oldest word
  always_comb begin
    occ_d    = occ_q;
    head_d   = head_q;
    tail_d   = tail_q;
    in_ready = rst_done_q && (occ_q != SK_FULL);
    wr_inc   = (occ_q != SK_EMPTY) && !wr_full;
    push     = in_valid && in_ready;
    unique case (occ_q)
      SK_EMPTY: begin
        if (push) begin
          head_d = in_data;
          occ_d  = SK_ONE;
        end
      end
      SK_ONE: begin
        // Simultaneous push/pop replaces the head in place, keeping order and count
        if (push && wr_inc) begin
          head_d = in_data;
        end else if (push) begin
          tail_d = in_data;
          occ_d  = SK_FULL;
        end else if (wr_inc) begin
          occ_d  = SK_EMPTY;
        end
      end
      SK_FULL: begin
        if (wr_inc) begin
          head_d = tail_q;
          occ_d  = SK_ONE;
        end
      end
      default: begin
        occ_d = SK_EMPTY;
      end
    endcase
  end

  assign wr_data = head_q;

  // Read-pointer synchronizer: plain flop chain, source is Gray coded
  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rd_ptr_async;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rd_ptr_sync = sync_q[SYNC_STAGES-1];

  // Modulo subtraction of binary pointers handles wrap of either pointer
  always_comb begin
    wr_bin = gray2bin(wr_ptr);
    rd_bin = gray2bin(rd_ptr_sync);
    fill_d = wr_bin - rd_bin;
  end

  // Registered fill level
  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      fill_level <= '0;
    end else begin
      fill_level <= fill_d;
    end
  end

`ifdef FIFO_WR_FRONT_ALMOST_FULL_EN
  localparam logic [ADD_WIDTH:0] AF_THR = (ADD_WIDTH+1)'(AF_LEVEL);

  // Almost-full flag computed from the same next value as fill_level
  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (fill_d >= AF_THR);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_front.sv
// Randomized scoreboard bench for fifo_wr_front with directed boundary cases.
module tb_fifo_wr_front;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int SS = 2;
  localparam int PW = AW + 1;

  logic          wr_clk       = 1'b0;
  logic          wr_rst       = 1'b0;
  logic [DW-1:0] in_data      = '0;
  logic          in_valid     = 1'b0;
  logic          in_ready;
  logic [PW-1:0] rd_ptr_async = '0;
  logic [PW-1:0] wr_ptr       = '0;
  logic          wr_full      = 1'b0;
  logic [PW-1:0] rd_ptr_sync;
  logic          wr_inc;
  logic [DW-1:0] wr_data;
  logic [PW-1:0] fill_level;
`ifdef FIFO_WR_FRONT_ALMOST_FULL_EN
  logic          almost_full;
`endif

  fifo_wr_front #(
    .DATA_WIDTH (DW),
    .ADD_WIDTH  (AW),
    .SYNC_STAGES(SS),
    .AF_LEVEL   (12)
  ) dut (
    .wr_clk      (wr_clk),
    .wr_rst      (wr_rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rd_ptr_async(rd_ptr_async),
    .wr_ptr      (wr_ptr),
    .wr_full     (wr_full),
    .rd_ptr_sync (rd_ptr_sync),
    .wr_inc      (wr_inc),
    .wr_data     (wr_data),
    .fill_level  (fill_level)
`ifdef FIFO_WR_FRONT_ALMOST_FULL_EN
    ,
    .almost_full (almost_full)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int            m_cnt = 0;
  bit            m_rdy = 1'b0;
  logic [PW-1:0] m_fill = '0;
  bit            m_af = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [PW-1:0] hist[$];
  logic [DW-1:0] obs_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int s = 1; s < PW; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Synchronized pointer = value seen SS edges ago, zero until that much history exists
  function automatic logic [PW-1:0] exp_sync();
    if (hist.size() == SS) return hist[0];
    return '0;
  endfunction

  // Behavioural model: occupancy count, accepted-word scoreboard, pointer history
  always @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      m_cnt  = 0;
      m_rdy  = 1'b0;
      m_fill = '0;
      m_af   = 1'b0;
      exp_q.delete();
      hist.delete();
    end else begin : upd
      logic [PW-1:0] fnew;
      bit            pop;
      bit            acc;
      fnew = g2b(wr_ptr) - g2b(exp_sync());
      pop  = (m_cnt != 0) && !wr_full;
      acc  = in_valid && m_rdy && (m_cnt < 2);
      if (acc) exp_q.push_back(in_data);
      m_cnt = m_cnt + int'(acc) - int'(pop);
      m_rdy = 1'b1;
      hist.push_back(rd_ptr_async);
      if (hist.size() > SS) void'(hist.pop_front());
      m_fill = fnew;
      m_af   = (32'(fnew) >= 12);
    end
  end

  // Monitor: compares every cycle, pops the scoreboard whenever a write is presented
  always @(negedge wr_clk) begin
    check("in_ready", 32'(in_ready), 32'(m_rdy && (m_cnt < 2)));
    check("wr_inc", 32'(wr_inc), 32'((m_cnt != 0) && !wr_full));
    check("rd_ptr_sync", 32'(rd_ptr_sync), 32'(exp_sync()));
    check("fill_level", 32'(fill_level), 32'(m_fill));
`ifdef FIFO_WR_FRONT_ALMOST_FULL_EN
    check("almost_full", 32'(almost_full), 32'(m_af));
`endif
    if (wr_inc === 1'b1) begin
      check("write_has_pending_word", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin : pop_blk
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        check("wr_data", 32'(wr_data), 32'(e));
        obs_q.push_back(wr_data);
      end
    end
  end

  // Offer one word and hold it until accepted, bounded
  task automatic send(input logic [DW-1:0] d);
    bit acc;
    in_data  = d;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge wr_clk);
      acc = in_ready;
      @(posedge wr_clk);
      #1;
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    check("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin : main
    logic [PW-1:0] rd_bin;

    // Reset held with in_valid asserted
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (3) @(posedge wr_clk);
    @(negedge wr_clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wr_inc", 32'(wr_inc), 32'd0);
    check("rst_fill", 32'(fill_level), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_sync", 32'(rd_ptr_sync), 32'd0);
    #2 wr_rst = 1'b1;
    #1 check("ready_before_first_edge", 32'(in_ready), 32'd0);
    @(negedge wr_clk);
    check("ready_after_first_edge", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(posedge wr_clk);
    #1;

    // Streaming 01..05 with no backpressure
    in_data  = 8'h01;
    in_valid = 1'b1;
    @(posedge wr_clk);
    #1;
    for (int i = 2; i <= 5; i++) begin
      in_data = DW'(i);
      @(negedge wr_clk);
      check("stream_inc", 32'(wr_inc), 32'd1);
      check("stream_data", 32'(wr_data), 32'(i - 1));
      @(posedge wr_clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge wr_clk);
    check("stream_inc_last", 32'(wr_inc), 32'd1);
    check("stream_data_last", 32'(wr_data), 32'h05);
    repeat (3) @(posedge wr_clk);
    #1;

    // Backpressure: two words stored, third held upstream
    obs_q.delete();
    wr_full = 1'b1;
    send(8'hA0);
    send(8'hA1);
    in_data  = 8'hA2;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge wr_clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_wr_inc", 32'(wr_inc), 32'd0);
      check("bp_head_held", 32'(wr_data), 32'hA0);
    end
    @(posedge wr_clk);
    #1;
    wr_full = 1'b0;
    send(8'hA2);
    repeat (4) @(posedge wr_clk);
    #1;
    check("bp_count", 32'(obs_q.size()), 32'd3);
    if (obs_q.size() == 3) begin
      check("bp_order0", 32'(obs_q[0]), 32'hA0);
      check("bp_order1", 32'(obs_q[1]), 32'hA1);
      check("bp_order2", 32'(obs_q[2]), 32'hA2);
    end

    // Synchronizer latency on a single Gray step
    rd_ptr_async = b2g(PW'(1));
    @(negedge wr_clk);
    check("sync_0_edges", 32'(rd_ptr_sync), 32'd0);
    @(negedge wr_clk);
    check("sync_1_edge", 32'(rd_ptr_sync), 32'd0);
    @(negedge wr_clk);
    check("sync_2_edges", 32'(rd_ptr_sync), 32'd1);
    @(posedge wr_clk);
    #1;

    // Fill level, including pointer wrap and equality
    rd_ptr_async = b2g(PW'(5'h03));
    wr_ptr       = b2g(PW'(5'h12));
    repeat (4) @(posedge wr_clk);
    @(negedge wr_clk);
    check("fill_15", 32'(fill_level), 32'd15);
    @(posedge wr_clk);
    #1;
    rd_ptr_async = b2g(PW'(5'h12));
    wr_ptr       = b2g(PW'(5'h02));
    repeat (4) @(posedge wr_clk);
    @(negedge wr_clk);
    check("fill_wrap_16", 32'(fill_level), 32'd16);
    @(posedge wr_clk);
    #1;
    rd_ptr_async = b2g(PW'(5'h07));
    wr_ptr       = b2g(PW'(5'h07));
    repeat (4) @(posedge wr_clk);
    @(negedge wr_clk);
    check("fill_equal_0", 32'(fill_level), 32'd0);
    @(posedge wr_clk);
    #1;
`ifdef FIFO_WR_FRONT_ALMOST_FULL_EN
    rd_ptr_async = '0;
    wr_ptr       = b2g(PW'(12));
    repeat (4) @(posedge wr_clk);
    @(negedge wr_clk);
    check("af_at_12", 32'(almost_full), 32'd1);
    @(posedge wr_clk);
    #1;
    wr_ptr = b2g(PW'(11));
    repeat (2) @(posedge wr_clk);
    @(negedge wr_clk);
    check("af_at_11", 32'(almost_full), 32'd0);
    @(posedge wr_clk);
    #1;
`endif

    // Randomized traffic, toggling wr_full window and a mid-run reset
    rd_bin = g2b(rd_ptr_async);
    for (int i = 0; i < 1200; i++) begin
      in_valid = ($urandom % 4) != 0;
      in_data  = DW'($urandom);
      if (i >= 400 && i < 500) wr_full = ~wr_full;
      else wr_full = ($urandom % 3) == 0;
      rd_bin       = rd_bin + PW'($urandom % 2);
      rd_ptr_async = b2g(rd_bin);
      wr_ptr       = b2g(rd_bin + PW'($urandom_range(0, 16)));
      if (i == 700) begin
        #2 wr_rst = 1'b0;
        @(negedge wr_clk);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge wr_clk);
        @(negedge wr_clk);
        #2 wr_rst = 1'b1;
      end
      @(posedge wr_clk);
      #1;
    end

    // Drain: every accepted word must have been written
    in_valid = 1'b0;
    wr_full  = 1'b0;
    repeat (6) @(posedge wr_clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
